// File: rtl/i2c_codec_responder_if.sv
// Bus bundle for the codec control-port responder: SCL in, ACK drive status,
// and the decoded register-write strobe with its address/data.
interface i2c_codec_responder_if;
    logic       i_sclk;
    logic       o_oen;
    logic       o_wr_valid;
    logic [6:0] o_wr_addr;
    logic [8:0] o_wr_data;
    logic       o_busy;
    logic       o_err;

    modport slave (
        input  i_sclk,
        output o_oen,
        output o_wr_valid,
        output o_wr_addr,
        output o_wr_data,
        output o_busy,
        output o_err
    );

    modport master (
        output i_sclk,
        input  o_oen,
        input  o_wr_valid,
        input  o_wr_addr,
        input  o_wr_data,
        input  o_busy,
        input  o_err
    );
endinterface

// File: rtl/i2c_codec_responder.sv
// I2C write-only target for the codec control port: oversamples SCL/SDA, ACKs
// frames to DEV_ADDR and turns each 3-byte frame into a 7-bit addr / 9-bit data strobe.
module i2c_codec_responder #(
    parameter logic [6:0]  DEV_ADDR    = 7'h1A,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    inout  wire                  o_sdat,
    i2c_codec_responder_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RECV = 2'd1,
        S_ACK  = 2'd2,
        S_SKIP = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_prev;
    logic                   r_sda_prev;

    state_t     r_state;
    logic [3:0] r_bit_cnt;
    logic [1:0] r_byte_idx;
    logic [7:0] r_shift;
    logic [6:0] r_reg_addr;
    logic       r_data_msb;
    logic [7:0] r_data_lsb;

    logic       r_oen;
    logic       r_wr_valid;
    logic [6:0] r_wr_addr;
    logic [8:0] r_wr_data;
    logic       r_busy;
    logic       r_err;

    logic w_scl;
    logic w_sda;
    logic w_scl_rise;
    logic w_scl_fall;
    logic w_start;
    logic w_stop;
    logic w_partial;
    logic w_addr_match;

    // Open-drain SDA: only ever pull low, otherwise release to the bus pull-up.
    assign o_sdat = r_oen ? 1'b0 : 1'bz;

    // Input synchronisers plus one extra sample for edge detection.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_scl_sync <= {SYNC_STAGES{1'b1}};
            r_sda_sync <= {SYNC_STAGES{1'b1}};
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], bus.i_sclk};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], o_sdat};
            r_scl_prev <= r_scl_sync[SYNC_STAGES-1];
            r_sda_prev <= r_sda_sync[SYNC_STAGES-1];
        end
    end

    assign w_scl        = r_scl_sync[SYNC_STAGES-1];
    assign w_sda        = r_sda_sync[SYNC_STAGES-1];
    assign w_scl_rise   = w_scl & ~r_scl_prev;
    assign w_scl_fall   = ~w_scl & r_scl_prev;
    assign w_start      = w_scl & r_scl_prev & r_sda_prev & ~w_sda;
    assign w_stop       = w_scl & r_scl_prev & ~r_sda_prev & w_sda;
    assign w_addr_match = (r_shift == {DEV_ADDR, 1'b0});

    // A restart aborts a frame if any data byte was ACKed or the address byte was in flight.
    assign w_partial = (r_byte_idx == 2'd1) || (r_byte_idx == 2'd2) ||
                       ((r_byte_idx == 2'd0) && (r_bit_cnt != 4'd0) &&
                        ((r_state == S_RECV) || (r_state == S_ACK)));

    // Protocol FSM; bus conditions win over bit sampling in the same cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_bit_cnt  <= 4'd0;
            r_byte_idx <= 2'd0;
            r_shift    <= 8'd0;
            r_reg_addr <= 7'd0;
            r_data_msb <= 1'b0;
            r_data_lsb <= 8'd0;
            r_oen      <= 1'b0;
            r_wr_valid <= 1'b0;
            r_wr_addr  <= 7'd0;
            r_wr_data  <= 9'd0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_wr_valid <= 1'b0;
            r_err      <= 1'b0;
            if (w_start) begin
                r_oen      <= 1'b0;
                r_bit_cnt  <= 4'd0;
                r_byte_idx <= 2'd0;
                r_busy     <= 1'b1;
                r_err      <= w_partial;
                r_state    <= S_RECV;
            end else if (w_stop) begin
                r_oen      <= 1'b0;
                r_busy     <= 1'b0;
                r_err      <= (r_byte_idx == 2'd1) || (r_byte_idx == 2'd2);
                r_bit_cnt  <= 4'd0;
                r_byte_idx <= 2'd0;
                r_state    <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_oen <= 1'b0;
                    end
                    S_RECV: begin
                        if (w_scl_rise && (r_bit_cnt < 4'd8)) begin
                            r_shift   <= {r_shift[6:0], w_sda};
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end else if (w_scl_fall && (r_bit_cnt == 4'd8)) begin
                            case (r_byte_idx)
                                2'd0: begin
                                    if (w_addr_match) begin
                                        r_oen   <= 1'b1;
                                        r_state <= S_ACK;
                                    end else begin
                                        r_err     <= 1'b1;
                                        r_bit_cnt <= 4'd0;
                                        r_state   <= S_SKIP;
                                    end
                                end
                                2'd1: begin
                                    r_reg_addr <= r_shift[7:1];
                                    r_data_msb <= r_shift[0];
                                    r_oen      <= 1'b1;
                                    r_state    <= S_ACK;
                                end
                                2'd2: begin
                                    r_data_lsb <= r_shift;
                                    r_oen      <= 1'b1;
                                    r_state    <= S_ACK;
                                end
                                default: begin
                                    r_err     <= 1'b1;
                                    r_bit_cnt <= 4'd0;
                                    r_state   <= S_SKIP;
                                end
                            endcase
                        end
                    end
                    S_ACK: begin
                        // The first fall seen here ends the 9th clock: release and advance.
                        if (w_scl_fall) begin
                            r_oen      <= 1'b0;
                            r_bit_cnt  <= 4'd0;
                            r_byte_idx <= r_byte_idx + 2'd1;
                            r_state    <= S_RECV;
                            if (r_byte_idx == 2'd2) begin
                                r_wr_addr  <= r_reg_addr;
                                r_wr_data  <= {r_data_msb, r_data_lsb};
                                r_wr_valid <= 1'b1;
                            end
                        end
                    end
                    S_SKIP: begin
                        r_oen <= 1'b0;
                    end
                    default: begin
                        r_oen   <= 1'b0;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.o_oen      = r_oen;
    assign bus.o_wr_valid = r_wr_valid;
    assign bus.o_wr_addr  = r_wr_addr;
    assign bus.o_wr_data  = r_wr_data;
    assign bus.o_busy     = r_busy;
    assign bus.o_err      = r_err;
endmodule

// File: tb/tb_i2c_codec_responder.sv
// Bench for i2c_codec_responder: bit-banged initiator, frame-level reference
// model feeding a write/error scoreboard that a negedge monitor drains.
module tb_i2c_codec_responder;
    localparam int Q = 6;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic m_low = 1'b0;
    wire  w_sda;

    int          n_total = 0;
    int          n_bad   = 0;
    logic [15:0] exp_wr[$];
    int          exp_err = 0;
    logic [6:0]  m_addr  = 7'd0;
    logic [8:0]  m_data  = 9'd0;

    i2c_codec_responder_if bus ();

    always #5 clk = ~clk;

    assign w_sda = m_low ? 1'b0 : 1'bz;
    pullup (w_sda);

    i2c_codec_responder #(.DEV_ADDR(7'h1A), .SYNC_STAGES(2)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .o_sdat (w_sda),
        .bus    (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wq(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.o_wr_valid) begin
                check("wr_err_exclusive", 32'(bus.o_err), 32'd0);
                if (exp_wr.size() == 0) begin
                    n_total++;
                    n_bad++;
                    $display("FAIL wr_unexpected: got addr 0x%0h data 0x%0h expected no write",
                             bus.o_wr_addr, bus.o_wr_data);
                end else begin
                    logic [15:0] e;
                    e = exp_wr.pop_front();
                    check("wr_addr", 32'(bus.o_wr_addr), 32'(e[15:9]));
                    check("wr_data", 32'(bus.o_wr_data), 32'(e[8:0]));
                end
            end
            if (bus.o_err) begin
                n_total++;
                if (exp_err == 0) begin
                    n_bad++;
                    $display("FAIL err_unexpected: got o_err=1 expected no error pulse");
                end else begin
                    exp_err--;
                end
            end
        end
    end

    task automatic send_start();
        m_low = 1'b0;
        wq(Q);
        bus.i_sclk = 1'b1;
        wq(2 * Q);
        m_low = 1'b1;
        wq(2 * Q);
        bus.i_sclk = 1'b0;
        wq(Q);
    endtask

    task automatic send_stop();
        m_low = 1'b1;
        wq(Q);
        bus.i_sclk = 1'b1;
        wq(2 * Q);
        m_low = 1'b0;
        wq(2 * Q);
    endtask

    task automatic send_bits(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            m_low = ~b[i];
            wq(Q);
            bus.i_sclk = 1'b1;
            wq(2 * Q);
            bus.i_sclk = 1'b0;
            wq(Q);
        end
    endtask

    task automatic ack_slot(input bit exp_ack);
        m_low = 1'b0;
        wq(Q);
        bus.i_sclk = 1'b1;
        wq(Q);
        check("ack_oen", 32'(bus.o_oen), 32'(exp_ack));
        check("ack_sda", 32'(w_sda), 32'(!exp_ack));
        wq(Q);
        bus.i_sclk = 1'b0;
        wq(Q);
    endtask

    // Frame-level model: which bytes are ACKed, how many errors, and the write (if any).
    task automatic run_frame(input logic [7:0] fb[5], input int n, input bit stop);
        bit acks[5];
        bit rejected = 1'b0;
        int n_ack    = 0;
        int errs     = 0;
        for (int i = 0; i < n; i++) begin
            acks[i] = 1'b0;
            if (rejected) begin
                acks[i] = 1'b0;
            end else if (i == 0) begin
                if (fb[0] == 8'h34) begin
                    acks[i] = 1'b1;
                    n_ack++;
                end else begin
                    rejected = 1'b1;
                    errs++;
                end
            end else if (i < 3) begin
                acks[i] = 1'b1;
                n_ack++;
            end else begin
                rejected = 1'b1;
                errs++;
            end
        end
        if (n_ack == 1 || n_ack == 2) errs++;
        if (n_ack == 3) begin
            m_addr = fb[1][7:1];
            m_data = {fb[1][0], fb[2]};
            exp_wr.push_back({m_addr, m_data});
        end
        exp_err += errs;

        send_start();
        check("busy_after_start", 32'(bus.o_busy), 32'd1);
        for (int i = 0; i < n; i++) begin
            send_bits(fb[i]);
            ack_slot(acks[i]);
        end
        if (stop) begin
            send_stop();
            check("busy_after_stop", 32'(bus.o_busy), 32'd0);
        end
        check("held_addr", 32'(bus.o_wr_addr), 32'(m_addr));
        check("held_data", 32'(bus.o_wr_data), 32'(m_data));
    endtask

    initial begin
        logic [7:0] fb[5];
        logic [8:0] d;
        int         kind;
        int         n;

        bus.i_sclk = 1'b1;
        m_low      = 1'b0;
        rst        = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rst_oen",      32'(bus.o_oen),      32'd0);
        check("rst_wr_valid", 32'(bus.o_wr_valid), 32'd0);
        check("rst_wr_addr",  32'(bus.o_wr_addr),  32'd0);
        check("rst_wr_data",  32'(bus.o_wr_data),  32'd0);
        check("rst_busy",     32'(bus.o_busy),     32'd0);
        check("rst_err",      32'(bus.o_err),      32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wq(4);

        fb = '{8'h34, 8'h12, 8'h01, 8'h00, 8'h00};
        run_frame(fb, 3, 1'b1);
        fb = '{8'h34, 8'h09, 8'h97, 8'h00, 8'h00};
        run_frame(fb, 3, 1'b1);
        fb = '{8'h36, 8'h12, 8'h01, 8'h00, 8'h00};
        run_frame(fb, 3, 1'b1);
        fb = '{8'h35, 8'hAA, 8'h00, 8'h00, 8'h00};
        run_frame(fb, 2, 1'b1);
        fb = '{8'h34, 8'h12, 8'h00, 8'h00, 8'h00};
        run_frame(fb, 2, 1'b1);

        for (int r = 0; r < 10; r++) begin
            d     = 9'($urandom);
            fb[0] = 8'h34;
            fb[1] = {7'(r), d[8]};
            fb[2] = d[7:0];
            run_frame(fb, 3, (r == 9));
        end

        for (int k = 0; k < 16; k++) begin
            kind = int'($urandom_range(0, 3));
            for (int i = 0; i < 5; i++) fb[i] = 8'($urandom);
            case (kind)
                0: begin fb[0] = 8'h34; n = 3; end
                1: begin
                    if (fb[0] == 8'h34) fb[0] = 8'h35;
                    n = int'($urandom_range(1, 3));
                end
                2: begin fb[0] = 8'h34; n = int'($urandom_range(1, 2)); end
                default: begin fb[0] = 8'h34; n = 4; end
            endcase
            run_frame(fb, n, (k == 15) ? 1'b1 : 1'($urandom_range(0, 1)));
        end

        // Reset while the address ACK is being driven.
        send_start();
        send_bits(8'h34);
        m_low = 1'b0;
        wq(Q);
        check("ack_before_rst", 32'(bus.o_oen), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_oen",      32'(bus.o_oen),      32'd0);
        check("midrst_wr_valid", 32'(bus.o_wr_valid), 32'd0);
        check("midrst_wr_addr",  32'(bus.o_wr_addr),  32'd0);
        check("midrst_wr_data",  32'(bus.o_wr_data),  32'd0);
        check("midrst_busy",     32'(bus.o_busy),     32'd0);
        check("midrst_err",      32'(bus.o_err),      32'd0);
        bus.i_sclk = 1'b1;
        m_low      = 1'b0;
        wq(3);
        rst    = 1'b0;
        m_addr = 7'd0;
        m_data = 9'd0;
        wq(4);

        fb = '{8'h34, 8'hA5, 8'h3C, 8'h00, 8'h00};
        run_frame(fb, 3, 1'b1);

        wq(20);
        check("wr_queue_drained", 32'(exp_wr.size()), 32'd0);
        check("err_drained",      32'(exp_err),       32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/i2c_codec_responder.md
Name: i2c_codec_responder

Overview:
- I2C target (slave) model of the audio codec's 2-wire control port; the receive end of the codec register-write stream.
- Oversamples SCL/SDA on the system clock, ACKs writes addressed to DEV_ADDR, and decodes each 3-byte frame into a 7-bit register address and 9-bit data word.
- Emits one write strobe per frame. Used as the codec stand-in in board-level benches and as a register shadow for debug readout.

Parameters:
- DEV_ADDR, 7'h1A, 7-bit target address. Address byte 0x34 is a write to this target.
- SYNC_STAGES, 2, flip-flop depth of the SCL/SDA input synchronisers (minimum 2).

Ports:
- i_clk, input, 1, system clock. Must be at least 8x the SCL frequency.
- i_rst, input, 1, synchronous, active-high reset.
- i_sclk, input, 1, I2C SCL from the initiator.
- o_sdat, inout, 1, I2C SDA. Driven 1'b0 when o_oen=1, otherwise 1'bz.
- o_oen, output, 1, 1 while this block pulls SDA low (ACK slot only).
- o_wr_valid, output, 1, one-cycle pulse when a complete frame has been accepted.
- o_wr_addr, output, 7, register address of the last accepted frame. Held until the next accepted frame.
- o_wr_data, output, 9, data of the last accepted frame. Held until the next accepted frame.
- o_busy, output, 1, 1 from START detect until STOP detect.
- o_err, output, 1, one-cycle pulse when a frame is aborted or rejected.

Behaviour:
- Reset values: o_oen=0 (SDA released), o_wr_valid=0, o_wr_addr=0, o_wr_data=0, o_busy=0, o_err=0, state=S_IDLE, bit and byte counters 0.
- Input conditioning:
  - SCL and SDA pass through SYNC_STAGES flops. Synchroniser flops reset to 1.
  - Edges are computed from the last two synchronised samples.
  - START = SDA falling while SCL high. STOP = SDA rising while SCL high.
  - Data bits are sampled on SCL rising edges only.
- States:
  - S_IDLE: wait for START, then go to S_RECV with byte_idx=0, bit_cnt=0, o_busy=1.
  - S_RECV: shift in one bit per SCL rise, MSB first. The 8th bit completes the byte. On the following SCL fall, decide:
    - Byte 0 with addr==DEV_ADDR and R/W=0: set o_oen=1, go to S_ACK.
    - Byte 0 otherwise (wrong address or R/W=1): leave SDA released (NACK), pulse o_err, go to S_SKIP.
    - Byte 1: latch reg_addr=byte[7:1] and data[8]=byte[0]; ACK.
    - Byte 2: latch data[7:0]; ACK.
    - Byte index 3 or more: NACK, pulse o_err, go to S_SKIP.
  - S_ACK: hold o_oen=1 through the 9th SCL high. On the next SCL fall, set o_oen=0 and byte_idx+1, then return to S_RECV. If the ACKed byte was byte 2, load o_wr_addr/o_wr_data and pulse o_wr_valid in the same cycle as the release.
  - S_SKIP: SDA released; ignore all bits until STOP or START.
- START or repeated START in any state:
  - Release SDA, clear counters, go to S_RECV.
  - If a frame was partially received (byte_idx 1 or 2, or byte 0 mid-shift), pulse o_err.
- STOP in any state:
  - Release SDA, o_busy=0, go to S_IDLE.
  - Pulse o_err if byte_idx was not 0 and not 3.
- Simultaneous events:
  - START/STOP detection takes priority over data sampling in the same cycle.
  - o_wr_valid and o_err are never both 1 in the same cycle.
- Timing:
  - Latency from the SCL fall that ends the 3rd ACK slot to o_wr_valid is SYNC_STAGES+1 i_clk cycles.
  - An ACK pull-down is asserted within SYNC_STAGES+1 cycles of the 8th-bit SCL fall.
- Reset mid-operation: o_oen=0 on the clock after i_rst=1 and all state returns to reset values. No write is emitted for an interrupted frame.
- Multi-frame: back-to-back frames separated by STOP+START (or by repeated START) each produce one o_wr_valid.

Test Plan:
- START, bytes 0x34 0x12 0x01, STOP -> three ACKs (o_oen=1 in each 9th slot), one o_wr_valid pulse with o_wr_addr=7'h09, o_wr_data=9'h001, o_err never 1.
- START, bytes 0x34 0x09 0x97, STOP -> o_wr_addr=7'h04, o_wr_data=9'h197.
- START, 0x36 (wrong address) and START, 0x35 (read) -> SDA released in the 9th slot, one o_err pulse each, no o_wr_valid, following bytes ignored until STOP.
- START, 0x34, 0x12, then STOP -> o_err pulse, o_wr_addr and o_wr_data unchanged, o_busy=0 after STOP.
- Ten initiator frames for registers 0x00 through 0x09 with repeated START between them -> exactly 10 o_wr_valid pulses, with addresses and data matching each frame in order.
- Assert i_rst while o_oen=1 during an ACK slot -> o_oen=0 on the next clock, all outputs at reset values, no write pulse.
